// File: rtl/router_input_ctrl.sv
// Router-node input controller: drains a first-word-fall-through FIFO, rewrites each packet
// header and streams the packet wormhole-style to one of NUM_OUT output allocators.
module router_input_ctrl #(
    parameter int PAYLOAD_W  = 10,
    parameter int NUM_OUT    = 4,
    parameter int ROUTE_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [PAYLOAD_W:0]   fifo_data,
    output logic                 fifo_rd,
    output logic [NUM_OUT-1:0]   out_req,
    input  logic [NUM_OUT-1:0]   out_ready,
    output logic [PAYLOAD_W:0]   out_data,
    output logic [15:0]          pkt_count,
    output logic                 route_err
);
    localparam int PORT_W = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic                 err;
        logic [PORT_W-1:0]    port;
        logic [PAYLOAD_W-1:0] payload;
    } hdr_t;

    function automatic hdr_t rewrite_hdr(input logic [PAYLOAD_W-1:0] payload);
        hdr_t h;
        h = '0;
        if (ROUTE_MODE == 1) begin
            // Positive hop counts go east (port 1) and count down; the rest fold to ~dest on port 0.
            if ($signed(payload) > 0) begin
                h.port    = PORT_W'(1);
                h.payload = payload - PAYLOAD_W'(1);
            end else begin
                h.port    = '0;
                h.payload = ~payload;
            end
        end else begin
            if (int'(payload[PORT_W-1:0]) >= NUM_OUT) begin
                h.port = PORT_W'(NUM_OUT - 1);
                h.err  = 1'b1;
            end else begin
                h.port = payload[PORT_W-1:0];
            end
            h.payload = payload >> PORT_W;
        end
        return h;
    endfunction

    state_t               state, state_next;
    logic                 out_valid, valid_next;
    logic [PORT_W-1:0]    sel, sel_next;
    logic [PAYLOAD_W:0]   data_next;
    logic [15:0]          count_next;
    logic                 err_next;
    logic [NUM_OUT-1:0]   sel_hot;
    logic                 xfer;
    logic                 tail_xfer;
    logic                 hdr_pop;
    hdr_t                 hdr;

    assign sel_hot   = NUM_OUT'(1) << sel;
    assign xfer      = out_valid && |(out_ready & sel_hot);
    assign tail_xfer = xfer && out_data[PAYLOAD_W];
    // The flit popped next is a header when idle or when the current tail leaves this cycle.
    assign hdr_pop   = (state == IDLE) || tail_xfer;
    assign fifo_rd   = reset && !fifo_empty && (!out_valid || xfer);
    assign out_req   = out_valid ? sel_hot : '0;
    assign hdr       = rewrite_hdr(fifo_data[PAYLOAD_W-1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sel       <= '0;
            out_data  <= '0;
            pkt_count <= '0;
            route_err <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
            sel       <= sel_next;
            out_data  <= data_next;
            pkt_count <= count_next;
            route_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        valid_next = out_valid;
        sel_next   = sel;
        data_next  = out_data;
        count_next = pkt_count;
        err_next   = route_err;

        if (xfer) valid_next = 1'b0;

        if (tail_xfer) begin
            count_next = pkt_count + 16'd1;
            state_next = IDLE;
        end

        if (fifo_rd) begin
            valid_next = 1'b1;
            if (hdr_pop) begin
                data_next  = {fifo_data[PAYLOAD_W], hdr.payload};
                sel_next   = hdr.port;
                err_next   = route_err | hdr.err;
                state_next = SEND;
            end else begin
                data_next  = fifo_data;
            end
        end
    end

endmodule

// File: doc/router_input_ctrl.md
Name: router_input_ctrl

Overview:
- Parametrised router-node input controller; one instance per router input.
- Drains a first-word-fall-through input FIFO and decodes the packet header to select one of NUM_OUT output allocators.
- Rewrites the header: source-route shift or signed hop-count.
- Streams the packet wormhole-style under a per-flit valid/ready handshake, locking the selected output until the tail flit has transferred.

Parameters:
PAYLOAD_W, 10, flit payload bits; flit = {tail, payload}, width PAYLOAD_W+1
NUM_OUT, 4, number of output allocators (>=2)
ROUTE_MODE, 0, 0 = source-route (shift), 1 = signed hop-count (requires NUM_OUT==2)
PORT_W, max(1,clog2(NUM_OUT)), derived route-field width; not overridden

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
fifo_empty  in  1  input FIFO empty
fifo_data  in  PAYLOAD_W+1  FIFO head flit, valid when ~fifo_empty; bit PAYLOAD_W = tail
fifo_rd  out  1  pop FIFO head this cycle
out_req  out  NUM_OUT  one-hot request/valid toward the selected allocator
out_ready  in  NUM_OUT  per-allocator ready
out_data  out  PAYLOAD_W+1  registered flit, shared by all outputs
pkt_count  out  16  completed packets; wraps 0xFFFF->0
route_err  out  1  sticky: out-of-range source-route field seen

Behaviour:
- Reset (reset==0, async): state=IDLE; out_valid=0; sel=0; out_data=0; out_req=0; fifo_rd=0; pkt_count=0; route_err=0.
  - Reset mid-packet abandons the packet; no flush; FIFO contents untouched.
- Internal state:
  - FSM IDLE/SEND.
  - out_valid: out_data holds an unsent flit.
  - sel: PORT_W bits, latched output index.
  - hdr_next: next popped flit is a header.
- Outputs:
  - out_req[i] = out_valid && (i==sel); all other bits 0.
  - fifo_rd = ~fifo_empty && (~out_valid || xfer), where xfer = out_valid && out_ready[sel].
  - fifo_rd is combinational. A popped flit lands in out_data on the next edge; latency FIFO head -> out_data/out_req = 1 cycle.
- IDLE:
  - If ~fifo_empty: pop the header, rewrite it, latch sel, set out_valid=1, then go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - On xfer of a non-tail flit: pop the next body flit if available, else out_valid=0. A bubble deasserts out_req; sel is held.
  - When out_valid==0 and ~fifo_empty: pop the body flit, out_valid=1.
  - On xfer of a tail flit: pkt_count+1. If ~fifo_empty, pop the next header the same cycle (back-to-back, no idle cycle), stay in SEND, and relatch sel. Else go to IDLE with out_valid=0.
- Throughput: 1 flit/cycle while out_ready[sel] is held high and the FIFO is non-empty.
- Tail bit passes through unchanged on every flit, including the header.
- Header rewrite, ROUTE_MODE 0:
  - sel = payload[PORT_W-1:0]; new payload = payload >> PORT_W (zero-fill).
  - If the field is >= NUM_OUT (non-power-of-two NUM_OUT): sel = NUM_OUT-1 and route_err<=1.
- Header rewrite, ROUTE_MODE 1:
  - dest = $signed(payload).
  - dest>0: sel=1, payload = dest-1.
  - dest<=0: sel=0, payload = ~dest (bitwise).
- Single-flit packet (header with tail=1) is legal: rewritten, sent, counted; completes like any tail.
- out_data and sel are stable while out_valid && ~out_ready[sel].
- out_ready of non-selected outputs is ignored.
- Body flits are never rewritten.

Test Plan:
1. ROUTE_MODE0, NUM_OUT=4, FIFO holds header 0x00E (tail0), body 0x155, tail-flit 0x4AA, out_ready=4'b1111.
   - fifo_rd asserted cycle 0; out_req=4'b0100 from cycle 1.
   - out_data = 0x003, 0x155, 0x4AA on cycles 1-3.
   - pkt_count=1; IDLE on cycle 4.
2. ROUTE_MODE1, NUM_OUT=2: header payload 0x005 -> out_req=2'b10, header out 0x004. Header payload 0x3FE (-2) -> out_req=2'b01, header out 0x001. Header payload 0 -> out_req=2'b01, header out 0x3FF.
3. Backpressure: drop out_ready[sel] for 3 cycles mid-packet.
   - out_data held; fifo_rd=0 throughout.
   - Resumes without loss or duplication; flit order preserved.
4. FIFO underrun mid-packet: empty for 2 cycles after the body flit.
   - out_req drops to 0; sel held.
   - Next flit goes to the same output with no header rewrite.
5. Back-to-back packets: tail of A and header of B (route 2) both present.
   - B's header popped on A's tail xfer cycle.
   - out_req switches from A's port to 4'b0100 on the next cycle; no bubble.
6. NUM_OUT=3, route field 3 -> sel=2, route_err=1 (sticky). Then assert reset low mid-packet -> all outputs 0 immediately and pkt_count=0.
